// File: rtl/reg_dbg_pkg.sv
// Shared types and default widths for the register-file debug port.
package reg_dbg_pkg;

  localparam int unsigned DBG_REG_W    = 5;
  localparam int unsigned DBG_DATA_W   = 64;
  localparam int unsigned DBG_NUM_REGS = 32;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_DUMP, OP_ILL} dbg_op_t;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} dbg_state_t;

endpackage

// File: rtl/reg_debug_port.sv
// Debug initiator for the integer register file: READ/WRITE/DUMP commands,
// register contents returned on a valid/ready response stream.
module reg_debug_port
  import reg_dbg_pkg::*;
#(
  parameter int unsigned REG_W    = DBG_REG_W,
  parameter int unsigned DATA_W   = DBG_DATA_W,
  parameter int unsigned NUM_REGS = DBG_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [REG_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_W-1:0]  rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cmd_err,
  output logic              busy,
  output logic [REG_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [REG_W-1:0]  rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

  dbg_state_t        state_q, state_d;
  dbg_op_t           op_q, op_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_d, cmd_err_d, busy_d, rsp_valid_d, rf_we_d;
  logic [REG_W-1:0]  rsp_addr_d, rf_raddr_d, rf_waddr_d;
  logic [DATA_W-1:0] rsp_data_d, rf_wdata_d;

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cmd_err_d  = 1'b0;
    rf_we_d    = 1'b0;
    rsp_addr_d = rsp_addr;
    rsp_data_d = rsp_data;
    rf_raddr_d = rf_raddr;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = dbg_op_t'(cmd_op);
          addr_d = cmd_addr;
          cnt_d  = '0;
          case (dbg_op_t'(cmd_op))
            OP_READ: begin
              rf_raddr_d = cmd_addr;
              state_d    = S_RD;
            end
            OP_WRITE: begin
              rf_waddr_d = cmd_addr;
              rf_wdata_d = cmd_wdata;
              rf_we_d    = 1'b1;
              state_d    = S_WR;
            end
            OP_DUMP: begin
              rf_raddr_d = '0;
              state_d    = S_RD;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      S_WR: begin
        // Read back the register just written.
        rf_raddr_d = addr_q;
        state_d    = S_RD;
      end
      S_RD: begin
        rsp_addr_d = rf_raddr;
        rsp_data_d = rf_rdata;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (op_q == OP_DUMP && cnt_q != LAST_REG) begin
            cnt_d      = cnt_q + REG_W'(1);
            rf_raddr_d = cnt_q + REG_W'(1);
            state_d    = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rf_raddr  <= '0;
      rf_waddr  <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      cmd_ready <= cmd_ready_d;
      cmd_err   <= cmd_err_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      rsp_addr  <= rsp_addr_d;
      rsp_data  <= rsp_data_d;
      rf_raddr  <= rf_raddr_d;
      rf_waddr  <= rf_waddr_d;
      rf_we     <= rf_we_d;
      rf_wdata  <= rf_wdata_d;
    end
  end

endmodule
